traffic_ped_request: RTL and testbench

//  Upstream front end for the traffic-light controller: conditions the raw pedestrian push-button
//  and produces the controller's start/enable level (o_start -> traffic.i_start).

---
 rtl/traffic_ped_request.sv | 148 ++++++++++++++
 tb/tb_traffic_ped_request.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ped_request.sv
// Pedestrian push-button front end for the traffic-light controller: sync, debounce, request latch, hold-off.
// Optional sticky timeout flag enabled by defining TRAFFIC_PED_TIMEOUT_EN.
module traffic_ped_request #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8,
  parameter int MAX_WAIT    = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_btn,
  input  logic             i_auto,
  input  logic [1:0]       i_walker_traffic,
  output logic             o_start,
  output logic             o_req_pending,
  output logic [CNT_W-1:0] o_wait_cnt,
  output logic             o_err,
  output logic [1:0]       o_dbg_state
);

  localparam int HOLD_LOAD = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int HOLD_W    = $clog2(HOLD_LOAD + 1);
  localparam int DEB_W     = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [1:0] WALK = 2'b01;

`ifdef TRAFFIC_PED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_SERVING = 2'd2,
    S_HOLDOFF = 2'd3
  } state_e;

  // Handshake: o_start is a level request held until the controller answers with
  // i_walker_traffic==WALK; the walk phase ending (walker leaving WALK) completes it.

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_q     <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic              walk;

  assign walk     = (i_walker_traffic == WALK);
  assign wait_inc = (wait_q == {CNT_W{1'b1}}) ? wait_q : wait_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    err_d   = err_q;
    start_d = 1'b0;
    pend_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_ARMED;
          wait_d  = '0;
        end
      end
      S_ARMED: begin
        wait_d = wait_inc;
        if (walk) state_d = S_SERVING;
      end
      S_SERVING: begin
        if (!walk) begin
          state_d = S_HOLDOFF;
          hold_d  = HOLD_W'(HOLD_LOAD);
        end
      end
      S_HOLDOFF: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      S_ARMED:   begin start_d = 1'b1;   pend_d = 1'b1; end
      S_SERVING: begin start_d = 1'b1;   pend_d = 1'b0; end
      default:   begin start_d = i_auto; pend_d = 1'b0; end
    endcase
    if (TIMEOUT_EN && state_q == S_ARMED && wait_d == CNT_W'(MAX_WAIT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign o_start       = start_q;
  assign o_req_pending = pend_q;
  assign o_wait_cnt    = wait_q;
  assign o_err         = err_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_traffic_ped_request.sv
// Directed bench for traffic_ped_request with DEB_CYCLES=4, HOLD_CYCLES=16, CNT_W=8.
module tb_traffic_ped_request;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_SERVING = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

`ifdef TRAFFIC_PED_TIMEOUT_EN
  localparam logic EXP_ERR_SAT = 1'b1;
`else
  localparam logic EXP_ERR_SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_btn;
  logic       i_auto;
  logic [1:0] i_walker_traffic;
  logic       o_start;
  logic       o_req_pending;
  logic [7:0] o_wait_cnt;
  logic       o_err;
  logic [1:0] o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  traffic_ped_request #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(16),
    .CNT_W      (8),
    .MAX_WAIT   (200)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_btn           (i_btn),
    .i_auto          (i_auto),
    .i_walker_traffic(i_walker_traffic),
    .o_start         (o_start),
    .o_req_pending   (o_req_pending),
    .o_wait_cnt      (o_wait_cnt),
    .o_err           (o_err),
    .o_dbg_state     (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the button and verify the request appears on exactly the 7th sampling edge.
  task automatic arm(input string tag, input logic [1:0] st_before);
    i_btn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      chk({tag, "_pend"}, o_req_pending, (i == 7));
      chk({tag, "_start"}, o_start, (i == 7) || i_auto);
      chk({tag, "_state"}, o_dbg_state, (i == 7) ? ST_ARMED : st_before);
    end
    chk({tag, "_wait0"}, o_wait_cnt, 0);
  endtask

  initial begin
    reset = 1'b1; i_btn = 1'b0; i_auto = 1'b0; i_walker_traffic = 2'b00;
    tick(3);
    chk("rst_start", o_start, 0);
    chk("rst_pend", o_req_pending, 0);
    chk("rst_wait", o_wait_cnt, 0);
    chk("rst_err", o_err, 0);
    reset = 1'b0;
    tick(1);
    chk("idle_start", o_start, 0);
    chk("idle_state", o_dbg_state, ST_IDLE);

    // Short glitch: 3 sampled cycles is below the debounce threshold.
    i_btn = 1'b1; tick(3); i_btn = 1'b0; tick(10);
    chk("glitch_pend", o_req_pending, 0);
    chk("glitch_start", o_start, 0);
    chk("glitch_state", o_dbg_state, ST_IDLE);

    // Normal request, service and hold-off.
    arm("a1", ST_IDLE);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("a1_wait", o_wait_cnt, i);
    end
    i_btn = 1'b0;
    i_walker_traffic = 2'b01;
    tick(1);
    chk("serve_state", o_dbg_state, ST_SERVING);
    chk("serve_pend", o_req_pending, 0);
    chk("serve_start", o_start, 1);
    chk("serve_wait", o_wait_cnt, 4);
    tick(1);
    chk("serve_stay", o_dbg_state, ST_SERVING);
    i_walker_traffic = 2'b10;
    tick(1);
    chk("hold_state", o_dbg_state, ST_HOLDOFF);
    chk("hold_start", o_start, 0);
    chk("hold_wait", o_wait_cnt, 4);
    // A full debounced press lands inside hold-off and must be discarded.
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk("hold_seq", o_dbg_state, (k < 16) ? ST_HOLDOFF : ST_IDLE);
      chk("hold_pend", o_req_pending, 0);
      if (k == 4) i_btn = 1'b1;
      if (k == 14) i_btn = 1'b0;
    end
    tick(8);
    chk("discard_state", o_dbg_state, ST_IDLE);
    chk("discard_pend", o_req_pending, 0);
    chk("discard_wait", o_wait_cnt, 4);

    // Second request: wait counter restarts; button stays held throughout.
    i_walker_traffic = 2'b00;
    arm("a2", ST_IDLE);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("a2_wait", o_wait_cnt, i);
    end
    i_walker_traffic = 2'b01; tick(1);
    chk("a2_serve", o_dbg_state, ST_SERVING);
    i_walker_traffic = 2'b00; tick(1);
    chk("a2_hold", o_dbg_state, ST_HOLDOFF);
    tick(16);
    chk("a2_idle", o_dbg_state, ST_IDLE);
    tick(20);
    chk("held_state", o_dbg_state, ST_IDLE);
    chk("held_pend", o_req_pending, 0);
    chk("held_start", o_start, 0);

    // Free-run mode in IDLE.
    i_auto = 1'b1; tick(1);
    chk("auto_idle_start", o_start, 1);
    i_btn = 1'b0; tick(10);
    chk("auto_idle_start2", o_start, 1);

    // Press while walk already shown: walk alone does nothing in IDLE, press arms, serve next edge.
    i_walker_traffic = 2'b01;
    arm("a3", ST_IDLE);
    tick(1);
    chk("a3_serve", o_dbg_state, ST_SERVING);
    chk("a3_pend", o_req_pending, 0);
    i_walker_traffic = 2'b10; tick(1);
    chk("a3_hold", o_dbg_state, ST_HOLDOFF);
    chk("auto_hold_start", o_start, 1);
    tick(16);
    chk("a3_idle", o_dbg_state, ST_IDLE);
    chk("auto_idle_start3", o_start, 1);
    i_btn = 1'b0; i_auto = 1'b0; i_walker_traffic = 2'b00;
    tick(10);
    chk("manual_start", o_start, 0);

    // Long wait with no walk feedback: counter saturates, request survives.
    arm("a4", ST_IDLE);
    tick(260);
    chk("sat_wait", o_wait_cnt, 255);
    chk("sat_state", o_dbg_state, ST_ARMED);
    chk("sat_err", o_err, EXP_ERR_SAT);
    i_walker_traffic = 2'b01; tick(1);
    chk("sat_serve", o_dbg_state, ST_SERVING);
    i_walker_traffic = 2'b00; tick(1);
    chk("sat_hold_wait", o_wait_cnt, 255);
    chk("sat_err_sticky", o_err, EXP_ERR_SAT);
    tick(16);
    i_btn = 1'b0; tick(10);

    // Asynchronous reset in the middle of ARMED.
    arm("a5", ST_IDLE);
    tick(5);
    chk("a5_wait", o_wait_cnt, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_start", o_start, 0);
    chk("arst_pend", o_req_pending, 0);
    chk("arst_wait", o_wait_cnt, 0);
    chk("arst_err", o_err, 0);
    chk("arst_state", o_dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0; i_btn = 1'b0;
    tick(1);
    chk("post_start", o_start, 0);
    chk("post_state", o_dbg_state, ST_IDLE);
    chk("post_pend", o_req_pending, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
